// File: rtl/game_step_scheduler_if.sv
// Scheduler <-> game datapath bundle: run/pause/score control, per-phase
// request/done handshakes, and status/debug outputs.
`timescale 1ns/1ps
interface game_step_scheduler_if #(
  parameter int unsigned CW = 20
) ();
  logic          run;
  logic          pause;
  logic [9:0]    score;
  logic          in_done;
  logic          move_done;
  logic          col_done;
  logic          collision;
  logic          in_req;
  logic          move_req;
  logic          col_req;
  logic          score_inc;
  logic          game_over;
  logic          fault;
  logic          overrun;
  logic [CW-1:0] period;
  logic [2:0]    state;

  // Scheduler side: issues requests, consumes dones and control.
  modport master (
    input  run, pause, score, in_done, move_done, col_done, collision,
    output in_req, move_req, col_req, score_inc, game_over, fault, overrun,
           period, state
  );

  // Environment side: datapath units and game control.
  modport slave (
    output run, pause, score, in_done, move_done, col_done, collision,
    input  in_req, move_req, col_req, score_inc, game_over, fault, overrun,
           period, state
  );
endinterface

// File: rtl/game_step_scheduler.sv
// Score-dependent game tick generator and per-step sequencer
// (sample -> move -> collide -> commit) with per-phase timeout and
// overrun detection. The tick period is latched once per tick, so a
// score change only takes effect on the following period.
`timescale 1ns/1ps
module game_step_scheduler #(
  parameter int unsigned PERIOD_MAX  = 500000,
  parameter int unsigned PERIOD_STEP = 500,
  parameter int unsigned PERIOD_MIN  = 50000,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned CW          = 20
) (
  input  logic                   clk,
  input  logic                   clr,
  game_step_scheduler_if.master  bus
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [CW-1:0] P_MAX  = CW'(PERIOD_MAX);
  localparam logic [CW-1:0] P_MIN  = CW'(PERIOD_MIN);
  localparam logic [CW-1:0] P_STEP = CW'(PERIOD_STEP);
  localparam logic [CW-1:0] P_SPAN = CW'(PERIOD_MAX - PERIOD_MIN);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    SAMPLE    = 3'd2,
    MOVE      = 3'd3,
    COLLIDE   = 3'd4,
    COMMIT    = 3'd5,
    OVER      = 3'd6
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic [CW-1:0] period_q;
  logic [TW-1:0] phase_cnt;
  logic          in_req_q;
  logic          move_req_q;
  logic          col_req_q;
  logic          score_inc_q;
  logic          game_over_q;
  logic          fault_q;
  logic          overrun_q;

  logic [CW-1:0] prod_c;
  logic [CW-1:0] next_period_c;
  logic          held_c;
  logic          tick_c;
  logic          timeout_c;
  logic          busy_c;

  // Period for the next tick: saturates at the minimum instead of wrapping.
  assign prod_c        = P_STEP * CW'(bus.score);
  assign next_period_c = (prod_c > P_SPAN) ? P_MIN : (P_MAX - prod_c);

  // Counter holds only while paused waiting for a tick.
  assign held_c    = (st == WAIT_TICK) && bus.pause;
  assign tick_c    = (st != IDLE) && !held_c && (cnt == (period_q - CW'(1)));
  assign timeout_c = (phase_cnt == T_LAST);
  assign busy_c    = (st == SAMPLE) || (st == MOVE) || (st == COLLIDE) || (st == COMMIT);

  // Tick counter, period latch and step sequencing FSM.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st          <= IDLE;
      cnt         <= '0;
      period_q    <= P_MAX;
      phase_cnt   <= '0;
      in_req_q    <= 1'b0;
      move_req_q  <= 1'b0;
      col_req_q   <= 1'b0;
      score_inc_q <= 1'b0;
      game_over_q <= 1'b0;
      fault_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (!bus.run) begin
      // Leaving the game: drop everything except the sticky status flags.
      st          <= IDLE;
      cnt         <= '0;
      phase_cnt   <= '0;
      in_req_q    <= 1'b0;
      move_req_q  <= 1'b0;
      col_req_q   <= 1'b0;
      score_inc_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      score_inc_q <= 1'b0;

      if (st == IDLE) begin
        cnt <= '0;
      end else if (tick_c) begin
        cnt      <= '0;
        period_q <= next_period_c;
      end else if (!held_c) begin
        cnt <= cnt + CW'(1);
      end

      // A tick during a step is dropped; the step keeps going.
      if (tick_c && busy_c) begin
        overrun_q <= 1'b1;
      end

      case (st)
        IDLE: begin
          st        <= WAIT_TICK;
          cnt       <= '0;
          period_q  <= next_period_c;
          fault_q   <= 1'b0;
          overrun_q <= 1'b0;
        end
        WAIT_TICK: begin
          if (tick_c) begin
            st        <= SAMPLE;
            in_req_q  <= 1'b1;
            phase_cnt <= '0;
          end
        end
        SAMPLE: begin
          if (bus.in_done) begin
            st         <= MOVE;
            in_req_q   <= 1'b0;
            move_req_q <= 1'b1;
            phase_cnt  <= '0;
          end else if (timeout_c) begin
            st       <= WAIT_TICK;
            in_req_q <= 1'b0;
            fault_q  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + TW'(1);
          end
        end
        MOVE: begin
          if (bus.move_done) begin
            st         <= COLLIDE;
            move_req_q <= 1'b0;
            col_req_q  <= 1'b1;
            phase_cnt  <= '0;
          end else if (timeout_c) begin
            st         <= WAIT_TICK;
            move_req_q <= 1'b0;
            fault_q    <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + TW'(1);
          end
        end
        COLLIDE: begin
          if (bus.col_done) begin
            col_req_q <= 1'b0;
            if (bus.collision) begin
              st          <= OVER;
              game_over_q <= 1'b1;
            end else begin
              st          <= COMMIT;
              score_inc_q <= 1'b1;
            end
          end else if (timeout_c) begin
            st        <= WAIT_TICK;
            col_req_q <= 1'b0;
            fault_q   <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + TW'(1);
          end
        end
        COMMIT: begin
          st <= WAIT_TICK;
        end
        OVER: begin
          st <= OVER;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_req    = in_req_q;
  assign bus.move_req  = move_req_q;
  assign bus.col_req   = col_req_q;
  assign bus.score_inc = score_inc_q;
  assign bus.game_over = game_over_q;
  assign bus.fault     = fault_q;
  assign bus.overrun   = overrun_q;
  assign bus.period    = period_q;
  assign bus.state     = st;

endmodule

// File: tb/tb_game_step_scheduler.sv
// Directed bench for game_step_scheduler with small periods
// (PERIOD_MAX=100, PERIOD_STEP=10, PERIOD_MIN=20, TIMEOUT=8).
`timescale 1ns/1ps
module tb_game_step_scheduler;

  logic clk = 1'b0;
  logic clr;

  game_step_scheduler_if #(.CW(20)) ifc ();

  game_step_scheduler #(
    .PERIOD_MAX (100),
    .PERIOD_STEP(10),
    .PERIOD_MIN (20),
    .TIMEOUT    (8),
    .CW         (20)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(ifc)
  );

  // 100 MHz bench clock.
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Responder settings: done rises after its req has been high for *_dly cycles.
  int in_dly = 1, move_dly = 1, col_dly = 1;
  bit col_hit = 1'b0;
  int in_cnt = 0, move_cnt = 0, col_cnt = 0;
  int in_rise = 0, inc_seen = 0;
  bit prev_in = 1'b0;

  // One clock, sampled 1 ns after the edge; models the datapath units.
  task automatic cycle();
    @(posedge clk);
    #1;
    in_cnt   = ifc.in_req   ? in_cnt + 1   : 0;
    move_cnt = ifc.move_req ? move_cnt + 1 : 0;
    col_cnt  = ifc.col_req  ? col_cnt + 1  : 0;
    ifc.in_done   = ifc.in_req   && (in_cnt >= in_dly);
    ifc.move_done = ifc.move_req && (move_cnt >= move_dly);
    ifc.col_done  = ifc.col_req  && (col_cnt >= col_dly);
    ifc.collision = col_hit;
    if (ifc.in_req && !prev_in) in_rise++;
    prev_in = ifc.in_req;
    if (ifc.score_inc) inc_seen++;
  endtask

  // Clock until in_req is seen high; n = cycles taken (capped at 400).
  task automatic wait_in_req(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!ifc.in_req && n < 400);
  endtask

  task automatic test_reset();
    clr     = 1'b1;
    ifc.run = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      ifc.in_done   = 1'($urandom_range(0, 1));
      ifc.move_done = 1'($urandom_range(0, 1));
      ifc.col_done  = 1'($urandom_range(0, 1));
      ifc.collision = 1'($urandom_range(0, 1));
    end
    checks++; if (ifc.state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", ifc.state); end
    checks++; if ({ifc.in_req, ifc.move_req, ifc.col_req, ifc.score_inc, ifc.game_over, ifc.fault, ifc.overrun} !== 7'b0)
      begin fails++; $display("FAIL reset_outputs: got %b want 0000000", {ifc.in_req, ifc.move_req, ifc.col_req, ifc.score_inc, ifc.game_over, ifc.fault, ifc.overrun}); end
    checks++; if (ifc.period !== 20'd100) begin fails++; $display("FAIL reset_period: got %0d want 100", ifc.period); end
    ifc.in_done = 1'b0; ifc.move_done = 1'b0; ifc.col_done = 1'b0; ifc.collision = 1'b0;
    clr = 1'b0;
    cycle();
    checks++; if (ifc.state !== 3'd1) begin fails++; $display("FAIL reset_release: state %0d want 1", ifc.state); end
  endtask

  task automatic test_step();
    int n;
    int inc0;
    inc0 = inc_seen;
    wait_in_req(n);
    checks++; if (n !== 100) begin fails++; $display("FAIL first_tick: in_req after %0d cycles want 100", n); end
    checks++; if (ifc.state !== 3'd2) begin fails++; $display("FAIL sample_state: got %0d want 2", ifc.state); end
    cycle();
    checks++; if ({ifc.state, ifc.in_req, ifc.move_req} !== {3'd3, 1'b0, 1'b1})
      begin fails++; $display("FAIL move_phase: state %0d in_req %b move_req %b want 3 0 1", ifc.state, ifc.in_req, ifc.move_req); end
    cycle();
    checks++; if ({ifc.state, ifc.move_req, ifc.col_req} !== {3'd4, 1'b0, 1'b1})
      begin fails++; $display("FAIL col_phase: state %0d move_req %b col_req %b want 4 0 1", ifc.state, ifc.move_req, ifc.col_req); end
    cycle();
    checks++; if ({ifc.state, ifc.col_req, ifc.score_inc} !== {3'd5, 1'b0, 1'b1})
      begin fails++; $display("FAIL commit_phase: state %0d col_req %b score_inc %b want 5 0 1", ifc.state, ifc.col_req, ifc.score_inc); end
    cycle();
    checks++; if ({ifc.state, ifc.score_inc} !== {3'd1, 1'b0})
      begin fails++; $display("FAIL commit_done: state %0d score_inc %b want 1 0", ifc.state, ifc.score_inc); end
    checks++; if (inc_seen !== inc0 + 1) begin fails++; $display("FAIL inc_pulse: got %0d pulses want 1", inc_seen - inc0); end
    wait_in_req(n);
    checks++; if (n !== 96) begin fails++; $display("FAIL second_tick: in_req after %0d cycles want 96", n); end
    repeat (4) cycle();
  endtask

  task automatic test_score_sweep();
    int n;
    ifc.score = 10'd5;
    repeat (50) cycle();
    checks++; if (ifc.period !== 20'd100) begin fails++; $display("FAIL period_mid: got %0d want 100", ifc.period); end
    wait_in_req(n);
    checks++; if (n !== 46) begin fails++; $display("FAIL tick_100: got %0d want 46", n); end
    checks++; if (ifc.period !== 20'd50) begin fails++; $display("FAIL period_s5: got %0d want 50", ifc.period); end
    repeat (4) cycle();
    ifc.score = 10'd8;
    wait_in_req(n);
    checks++; if (n !== 46) begin fails++; $display("FAIL tick_50: got %0d want 46", n); end
    checks++; if (ifc.period !== 20'd20) begin fails++; $display("FAIL period_s8: got %0d want 20", ifc.period); end
    repeat (4) cycle();
    ifc.score = 10'd9;
    wait_in_req(n);
    checks++; if (n !== 16) begin fails++; $display("FAIL tick_20a: got %0d want 16", n); end
    checks++; if (ifc.period !== 20'd20) begin fails++; $display("FAIL period_s9: got %0d want 20", ifc.period); end
    repeat (4) cycle();
    ifc.score = 10'd1023;
    wait_in_req(n);
    checks++; if (n !== 16) begin fails++; $display("FAIL tick_20b: got %0d want 16", n); end
    checks++; if (ifc.period !== 20'd20) begin fails++; $display("FAIL period_s1023: got %0d want 20", ifc.period); end
    repeat (4) cycle();
  endtask

  task automatic test_timeout();
    int n;
    int inc0;
    move_dly = 1000;
    inc0 = inc_seen;
    wait_in_req(n);
    cycle();
    checks++; if (ifc.move_req !== 1'b1) begin fails++; $display("FAIL to_move_req: got %b want 1", ifc.move_req); end
    repeat (7) cycle();
    checks++; if ({ifc.state, ifc.move_req, ifc.fault} !== {3'd3, 1'b1, 1'b0})
      begin fails++; $display("FAIL to_early: state %0d move_req %b fault %b want 3 1 0", ifc.state, ifc.move_req, ifc.fault); end
    cycle();
    checks++; if ({ifc.state, ifc.move_req, ifc.fault, ifc.score_inc} !== {3'd1, 1'b0, 1'b1, 1'b0})
      begin fails++; $display("FAIL to_fire: state %0d move_req %b fault %b score_inc %b want 1 0 1 0", ifc.state, ifc.move_req, ifc.fault, ifc.score_inc); end
    move_dly = 1;
    wait_in_req(n);
    checks++; if (inc_seen !== inc0) begin fails++; $display("FAIL to_no_inc: got %0d pulses want 0", inc_seen - inc0); end
    checks++; if (n !== 11) begin fails++; $display("FAIL to_next_tick: got %0d want 11", n); end
    repeat (4) cycle();
    checks++; if ({inc_seen - inc0, ifc.fault} !== {32'd1, 1'b1})
      begin fails++; $display("FAIL to_sticky: pulses %0d fault %b want 1 1", inc_seen - inc0, ifc.fault); end
    ifc.run = 1'b0;
    cycle();
    checks++; if ({ifc.state, ifc.fault} !== {3'd0, 1'b1})
      begin fails++; $display("FAIL to_idle_hold: state %0d fault %b want 0 1", ifc.state, ifc.fault); end
    ifc.run = 1'b1;
    cycle();
    checks++; if ({ifc.state, ifc.fault} !== {3'd1, 1'b0})
      begin fails++; $display("FAIL to_clear: state %0d fault %b want 1 0", ifc.state, ifc.fault); end
  endtask

  task automatic test_collision();
    int n;
    int reqs = 0;
    col_hit = 1'b1;
    wait_in_req(n);
    repeat (3) cycle();
    checks++; if ({ifc.state, ifc.game_over, ifc.col_req} !== {3'd6, 1'b1, 1'b0})
      begin fails++; $display("FAIL col_over: state %0d game_over %b col_req %b want 6 1 0", ifc.state, ifc.game_over, ifc.col_req); end
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (ifc.in_req || ifc.move_req || ifc.col_req || ifc.score_inc) reqs++;
    end
    checks++; if (reqs !== 0) begin fails++; $display("FAIL over_quiet: %0d active cycles want 0", reqs); end
    checks++; if ({ifc.state, ifc.game_over, ifc.overrun} !== {3'd6, 1'b1, 1'b0})
      begin fails++; $display("FAIL over_hold: state %0d game_over %b overrun %b want 6 1 0", ifc.state, ifc.game_over, ifc.overrun); end
    ifc.run = 1'b0;
    cycle();
    checks++; if ({ifc.state, ifc.game_over} !== {3'd0, 1'b0})
      begin fails++; $display("FAIL over_exit: state %0d game_over %b want 0 0", ifc.state, ifc.game_over); end
    col_hit = 1'b0;
  endtask

  task automatic test_overrun_pause();
    int n;
    int k;
    int rise0;
    int inc0;
    ifc.score = 10'd9;
    in_dly = 7; move_dly = 7; col_dly = 7;
    ifc.run = 1'b1;
    cycle();
    rise0 = in_rise;
    inc0  = inc_seen;
    wait_in_req(n);
    checks++; if (n !== 20) begin fails++; $display("FAIL ov_first_tick: got %0d want 20", n); end
    k = 0;
    do begin
      cycle();
      k++;
    end while (ifc.state !== 3'd1 && k < 100);
    checks++; if (k !== 22) begin fails++; $display("FAIL ov_step_len: got %0d want 22", k); end
    checks++; if (ifc.overrun !== 1'b1) begin fails++; $display("FAIL ov_flag: got %b want 1", ifc.overrun); end
    checks++; if ({inc_seen - inc0, in_rise - rise0} !== {32'd1, 32'd1})
      begin fails++; $display("FAIL ov_one_step: pulses %0d in_req rises %0d want 1 1", inc_seen - inc0, in_rise - rise0); end
    in_dly = 1; move_dly = 1; col_dly = 1;
    ifc.pause = 1'b1;
    repeat (10) cycle();
    checks++; if ({ifc.state, ifc.in_req} !== {3'd1, 1'b0})
      begin fails++; $display("FAIL pause_hold: state %0d in_req %b want 1 0", ifc.state, ifc.in_req); end
    ifc.pause = 1'b0;
    wait_in_req(n);
    checks++; if (n !== 18) begin fails++; $display("FAIL pause_delay: got %0d want 18", n); end
    checks++; if (in_rise - rise0 !== 2) begin fails++; $display("FAIL pause_rises: got %0d want 2", in_rise - rise0); end
  endtask

  task automatic test_async_clr();
    clr = 1'b1;
    #2;
    checks++; if (ifc.state !== 3'd0) begin fails++; $display("FAIL aclr_state: got %0d want 0", ifc.state); end
    checks++; if ({ifc.in_req, ifc.move_req, ifc.col_req, ifc.score_inc, ifc.game_over, ifc.fault, ifc.overrun} !== 7'b0)
      begin fails++; $display("FAIL aclr_outputs: got %b want 0000000", {ifc.in_req, ifc.move_req, ifc.col_req, ifc.score_inc, ifc.game_over, ifc.fault, ifc.overrun}); end
    checks++; if (ifc.period !== 20'd100) begin fails++; $display("FAIL aclr_period: got %0d want 100", ifc.period); end
  endtask

  initial begin
    clr           = 1'b1;
    ifc.run       = 1'b0;
    ifc.pause     = 1'b0;
    ifc.score     = 10'd0;
    ifc.in_done   = 1'b0;
    ifc.move_done = 1'b0;
    ifc.col_done  = 1'b0;
    ifc.collision = 1'b0;
    test_reset();
    test_step();
    test_score_sweep();
    test_timeout();
    test_collision();
    test_overrun_pause();
    test_async_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
